// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment display driver: a sequential binary-to-digits converter
// (divide-by-60, then double-dabble) feeding an independently scanned digit register.
module seg_scan_display #(
    parameter int DIGITS      = 4,
    parameter int VW          = 16,
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [VW-1:0]     value,
    input  logic [1:0]        mode,
    output logic [DIGITS-1:0] anode,
    output logic [6:0]        segment,
    output logic              dp,
    output logic              busy,
    output logic              overflow
);
    // BCD register is sized for the full input range so overflow can be seen above DIGITS
    localparam int BN   = ((VW * 30103) / 100000 + 2 > DIGITS) ? (VW * 30103) / 100000 + 2 : DIGITS;
    localparam int BCDW = 4 * BN;
    localparam int CW   = $clog2(VW + 1);
    localparam int RW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int HW   = VW + 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, DIV, BCD, LOAD} state_t;
    typedef enum logic [1:0] {M_DEC = 2'd0, M_MMSS = 2'd1, M_HEX = 2'd2, M_BLANK = 2'd3} mode_t;
    typedef struct packed {
        logic       blank;
        logic [3:0] nib;
    } glyph_t;

    localparam glyph_t BLANK_GLYPH = '{blank: 1'b1, nib: 4'h0};

    state_t          state;
    mode_t           sh_mode, disp_mode;
    logic [VW-1:0]   sh_value, div_q, bin_sh;
    logic [5:0]      div_r;
    logic [CW-1:0]   cnt;
    logic [BCDW-1:0] bcd;
    glyph_t          disp [DIGITS];
    glyph_t          load_glyph [DIGITS];
    logic            load_ovf;
    logic [RW-1:0]   rcnt;
    logic [IW-1:0]   idx;

    function automatic logic [BCDW-1:0] dabble(input logic [BCDW-1:0] b);
        logic [BCDW-1:0] r;
        r = b;
        for (int i = 0; i < BN; i++)
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input glyph_t g);
        if (g.blank) return 7'h7F;
        case (g.nib)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    // One restoring step: shift the next dividend bit into the remainder, subtract 60 if it fits
    logic [6:0]    rem_try;
    logic          div_ge;
    logic [5:0]    div_r_nxt;
    logic [VW-1:0] div_q_nxt;
    assign rem_try   = {div_r, div_q[VW-1]};
    assign div_ge    = (rem_try >= 7'd60);
    assign div_r_nxt = div_ge ? 6'(rem_try - 7'd60) : rem_try[5:0];
    assign div_q_nxt = {div_q[VW-2:0], div_ge};

    logic [3:0]    tens, ones;
    logic [HW-1:0] hex_ext;
    logic          lz;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        load_ovf = 1'b0;
        lz       = 1'b1;
        hex_ext  = HW'(sh_value);
        tens     = 4'd0;
        for (int t = 1; t <= 5; t++)
            if (div_r >= 6'(10 * t)) tens = 4'(t);
        ones = 4'(div_r - {2'b00, tens} * 6'd10);
        for (int i = 0; i < DIGITS; i++) load_glyph[i] = BLANK_GLYPH;

        case (sh_mode)
            M_DEC: begin
                load_ovf = |(bcd >> (4 * DIGITS));
                for (int i = 0; i < DIGITS; i++)
                    load_glyph[i] = '{blank: 1'b0, nib: load_ovf ? 4'd9 : bcd[4*(DIGITS-1-i) +: 4]};
            end
            M_MMSS: begin
                load_ovf = |(bcd >> (4 * (DIGITS - 2)));
                for (int i = 0; i < DIGITS - 2; i++)
                    load_glyph[i] = '{blank: 1'b0, nib: load_ovf ? 4'd9 : bcd[4*(DIGITS-3-i) +: 4]};
                load_glyph[DIGITS-2] = '{blank: 1'b0, nib: load_ovf ? 4'd5 : tens};
                load_glyph[DIGITS-1] = '{blank: 1'b0, nib: load_ovf ? 4'd9 : ones};
            end
            M_HEX: begin
                load_ovf = |(hex_ext >> (4 * DIGITS));
                for (int i = 0; i < DIGITS; i++)
                    load_glyph[i] = '{blank: 1'b0, nib: load_ovf ? 4'hF : hex_ext[4*(DIGITS-1-i) +: 4]};
            end
            default: ;
        endcase

        // The rightmost digit is never blanked, so a zero value still shows "0"
        if (BLANK_LZ && (sh_mode == M_DEC || sh_mode == M_HEX)) begin
            for (int i = 0; i < DIGITS - 1; i++) begin
                if (lz && load_glyph[i].nib == 4'h0) load_glyph[i].blank = 1'b1;
                else lz = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            sh_mode   <= M_BLANK;
            sh_value  <= '0;
            cnt       <= '0;
            div_q     <= '0;
            div_r     <= '0;
            bin_sh    <= '0;
            bcd       <= '0;
            disp_mode <= M_BLANK;
            // NOTE: the display register is a handful of flops, not a RAM, so resetting it is cheap and keeps power-up blank.
            for (int i = 0; i < DIGITS; i++) disp[i] <= BLANK_GLYPH;
        end else begin
            case (state)
                IDLE: begin
                    sh_value <= value;
                    sh_mode  <= mode_t'(mode);
                    cnt      <= '0;
                    bcd      <= '0;
                    div_q    <= value;
                    div_r    <= '0;
                    bin_sh   <= value;
                    busy     <= 1'b1;
                    case (mode_t'(mode))
                        M_MMSS:  state <= DIV;
                        M_DEC:   state <= BCD;
                        default: state <= LOAD;
                    endcase
                end
                DIV: begin
                    div_q  <= div_q_nxt;
                    div_r  <= div_r_nxt;
                    bin_sh <= div_q_nxt;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(VW - 1)) begin
                        cnt   <= '0;
                        state <= BCD;
                    end
                end
                BCD: begin
                    bcd    <= BCDW'({dabble(bcd), bin_sh[VW-1]});
                    bin_sh <= bin_sh << 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(VW - 1)) state <= LOAD;
                end
                LOAD: begin
                    disp      <= load_glyph;
                    disp_mode <= sh_mode;
                    overflow  <= load_ovf;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Scan side: free-running, reads the display register only, so it never sees a half-written value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt    <= '0;
            idx     <= '0;
            anode   <= '1;
            segment <= 7'h7F;
            dp      <= 1'b1;
        end else begin
            if (rcnt == RW'(REFRESH_DIV - 1)) begin
                rcnt <= '0;
                idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                rcnt <= rcnt + 1'b1;
            end

            if (disp_mode == M_BLANK) begin
                anode   <= '1;
                segment <= 7'h7F;
                dp      <= 1'b1;
            end else begin
                anode   <= ~(DIGITS'(1) << (IW'(DIGITS - 1) - idx));
                segment <= seg_decode(disp[idx]);
                dp      <= !(disp_mode == M_MMSS && idx == IW'(DIGITS - 3));
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display (4 digits, 16-bit value, 4-cycle refresh):
// hand-computed glyphs for each mode, overflow, reset and mid-conversion input changes.
module tb_seg_scan_display;
    localparam int DIGITS      = 4;
    localparam int VW          = 16;
    localparam int REFRESH_DIV = 4;

    localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010;
    localparam logic [6:0] G3 = 7'b0000110, G4 = 7'b1001100, G5 = 7'b0100100;
    localparam logic [6:0] G9 = 7'b0000100, GB = 7'b1100000, GE = 7'b0110000;
    localparam logic [6:0] GF = 7'b0111000, BL = 7'h7F;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [VW-1:0]     value;
    logic [1:0]        mode;
    logic [DIGITS-1:0] anode;
    logic [6:0]        segment;
    logic              dp, busy, overflow;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seg_scan_display #(
        .DIGITS(DIGITS), .VW(VW), .REFRESH_DIV(REFRESH_DIV), .BLANK_LZ(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .mode(mode),
        .anode(anode), .segment(segment), .dp(dp), .busy(busy), .overflow(overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Walks the scan once, digit 0 (leftmost) to digit 3, checking glyph and dp on each
    task automatic check_disp(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3, input logic mmss);
        logic [6:0] exp_seg [4];
        exp_seg = '{s0, s1, s2, s3};
        for (int k = 0; k < 4; k++) begin
            logic [3:0] exp_an;
            int n;
            exp_an = ~(4'b1000 >> k);
            n = 0;
            while (anode !== exp_an && n < 40) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("%s anode d%0d", tag, k), 32'(anode), 32'(exp_an));
            check($sformatf("%s seg d%0d", tag, k), 32'(segment), 32'(exp_seg[k]));
            check($sformatf("%s dp d%0d", tag, k), 32'(dp), (mmss && k == 1) ? 32'd0 : 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] old_g [4];
        logic [6:0] new_g [4];
        int  n, k, sw_at;
        logic switched;

        rst_n = 1'b0;
        value = '0;
        mode  = 2'd0;
        #12;
        check("reset anode", 32'(anode), 32'hF);
        check("reset seg", 32'(segment), 32'h7F);
        check("reset dp", 32'(dp), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // mm:ss 754 s = 12:34
        mode  = 2'd1;
        value = 16'd754;
        wait_cycles(75);
        check_disp("mmss754", G1, G2, G3, G4, 1'b1);
        check("mmss754 ovf", 32'(overflow), 32'd0);

        // decimal with leading-zero blanking
        mode  = 2'd0;
        value = 16'd42;
        wait_cycles(75);
        check_disp("dec42", BL, BL, G4, G2, 1'b0);
        value = 16'd0;
        wait_cycles(75);
        check_disp("dec0", BL, BL, BL, G0, 1'b0);

        // decimal overflow saturates at 9999
        value = 16'd12345;
        wait_cycles(75);
        check_disp("dec12345", G9, G9, G9, G9, 1'b0);
        check("dec12345 ovf", 32'(overflow), 32'd1);

        // asynchronous reset mid-scan with overflow set, no clock edge in between
        #2 rst_n = 1'b0;
        #1;
        check("midreset anode", 32'(anode), 32'hF);
        check("midreset seg", 32'(segment), 32'h7F);
        check("midreset dp", 32'(dp), 32'd1);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset ovf", 32'(overflow), 32'd0);
        mode  = 2'd1;
        value = 16'd6000;
        @(negedge clk);
        rst_n = 1'b1;

        // mm:ss overflow: 100 minutes saturates at 99:59
        wait_cycles(75);
        check_disp("mmss6000", G9, G9, G5, G9, 1'b1);
        check("mmss6000 ovf", 32'(overflow), 32'd1);

        mode  = 2'd0;
        value = 16'd9999;
        wait_cycles(75);
        check_disp("dec9999", G9, G9, G9, G9, 1'b0);
        check("dec9999 ovf", 32'(overflow), 32'd0);

        // hex
        mode  = 2'd2;
        value = 16'hBEEF;
        wait_cycles(75);
        check_disp("hexBEEF", GB, GE, GE, GF, 1'b0);
        check("hexBEEF ovf", 32'(overflow), 32'd0);

        // blank mode: all digits off while the scan keeps running
        mode = 2'd3;
        wait_cycles(75);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("blank anode s%0d", i), 32'(anode), 32'hF);
            check($sformatf("blank seg s%0d", i), 32'(segment), 32'h7F);
            wait_cycles(REFRESH_DIV);
        end

        // value change during DIV: 12:34 must persist until the next LOAD, then 00:01 atomically
        mode  = 2'd1;
        value = 16'd754;
        wait_cycles(75);
        n = 0;
        while (busy !== 1'b0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        check("t6 idle sync", 32'(busy), 32'd0);
        @(negedge clk);
        check("t6 busy in div", 32'(busy), 32'd1);
        value    = 16'd1;
        old_g    = '{G1, G2, G3, G4};
        new_g    = '{G0, G0, G0, G1};
        switched = 1'b0;
        sw_at    = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            k = -1;
            for (int j = 0; j < 4; j++)
                if (anode === ~(4'b1000 >> j)) k = j;
            if (k < 0) begin
                check($sformatf("t6 anode c%0d", i), 32'(anode), 32'(~(4'b1000 >> 0)));
            end else begin
                if (!switched && segment === new_g[k] && segment !== old_g[k]) begin
                    switched = 1'b1;
                    sw_at    = i;
                end
                check($sformatf("t6 nomix c%0d", i), 32'(segment), switched ? 32'(new_g[k]) : 32'(old_g[k]));
            end
        end
        check("t6 switched", 32'(switched), 32'd1);
        check("t6 switch cycle", 32'(sw_at), 32'd67);
        check_disp("mmss1", G0, G0, G0, G1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
